// File: rtl/datapath_pkg.sv
// Shared constants for the single-bus datapath:
// widths, ALU opcodes and bus source codes.
package datapath_pkg;

    localparam int W    = 32;
    localparam int NREG = 16;
    localparam int AW   = 9;

    localparam logic [4:0] OP_LD   = 5'd0;
    localparam logic [4:0] OP_LDI  = 5'd1;
    localparam logic [4:0] OP_ST   = 5'd2;
    localparam logic [4:0] OP_ADD  = 5'd3;
    localparam logic [4:0] OP_SUB  = 5'd4;
    localparam logic [4:0] OP_AND  = 5'd5;
    localparam logic [4:0] OP_OR   = 5'd6;
    localparam logic [4:0] OP_ROR  = 5'd7;
    localparam logic [4:0] OP_ROL  = 5'd8;
    localparam logic [4:0] OP_SHR  = 5'd9;
    localparam logic [4:0] OP_SHRA = 5'd10;
    localparam logic [4:0] OP_SHL  = 5'd11;
    localparam logic [4:0] OP_ADDI = 5'd12;
    localparam logic [4:0] OP_ANDI = 5'd13;
    localparam logic [4:0] OP_ORI  = 5'd14;
    localparam logic [4:0] OP_DIV  = 5'd15;
    localparam logic [4:0] OP_MUL  = 5'd16;
    localparam logic [4:0] OP_NEG  = 5'd17;
    localparam logic [4:0] OP_NOT  = 5'd18;
    localparam logic [4:0] OP_BR   = 5'd19;

    localparam logic [4:0] SRC_HI  = 5'd16;
    localparam logic [4:0] SRC_LO  = 5'd17;
    localparam logic [4:0] SRC_ZHI = 5'd18;
    localparam logic [4:0] SRC_ZLO = 5'd19;
    localparam logic [4:0] SRC_PC  = 5'd20;
    localparam logic [4:0] SRC_MDR = 5'd21;
    localparam logic [4:0] SRC_IN  = 5'd22;
    localparam logic [4:0] SRC_C   = 5'd23;
    localparam logic [4:0] SRC_Y   = 5'd24;

endpackage

// File: rtl/datapath_alu.sv
// Datapath ALU: A=Y, B=bus, 64-bit result {Zhi,Zlo}.
// IncPC forces bus+1 regardless of opcode.
module alu
    import datapath_pkg::*;
(
    input  logic [W-1:0]   i_a,
    input  logic [W-1:0]   i_b,
    input  logic [4:0]     i_op,
    input  logic           i_incpc,
    output logic [2*W-1:0] o_res
);

    logic [4:0]          w_sh;
    logic [2*W-1:0]      w_ror;
    logic [2*W-1:0]      w_rol;
    logic signed [2*W-1:0] w_sa64;
    logic signed [2*W-1:0] w_sb64;
    logic signed [2*W-1:0] w_prod;
    logic signed [W-1:0] w_sa;
    logic signed [W-1:0] w_sb;
    logic signed [W-1:0] w_q;
    logic signed [W-1:0] w_r;

    assign w_sh   = i_b[4:0];
    assign w_ror  = {i_a, i_a} >> w_sh;
    assign w_rol  = {i_a, i_a} << w_sh;
    assign w_sa64 = {{W{i_a[W-1]}}, i_a};
    assign w_sb64 = {{W{i_b[W-1]}}, i_b};
    assign w_prod = w_sa64 * w_sb64;
    assign w_sa   = i_a;
    assign w_sb   = i_b;
    assign w_q    = w_sa / w_sb;
    assign w_r    = w_sa % w_sb;

    // Opcode decode; upper word is zero except for mul/div
    always_comb begin
        o_res = '0;
        if (i_incpc) begin
            o_res[W-1:0] = i_b + 32'd1;
        end else begin
            case (i_op)
                OP_LD, OP_LDI, OP_ST,
                OP_ADD, OP_ADDI, OP_BR:
                    o_res[W-1:0] = i_a + i_b;
                OP_SUB:  o_res[W-1:0] = i_a - i_b;
                OP_AND, OP_ANDI:
                    o_res[W-1:0] = i_a & i_b;
                OP_OR, OP_ORI:
                    o_res[W-1:0] = i_a | i_b;
                OP_ROR:  o_res[W-1:0] = w_ror[W-1:0];
                OP_ROL:  o_res[W-1:0] = w_rol[2*W-1:W];
                OP_SHR:  o_res[W-1:0] = i_a >> w_sh;
                OP_SHRA: o_res[W-1:0] = $unsigned(w_sa >>> w_sh);
                OP_SHL:  o_res[W-1:0] = i_a << w_sh;
                OP_MUL:  o_res = $unsigned(w_prod);
                OP_DIV: begin
                    if (i_b != '0) begin
                        o_res = {$unsigned(w_r), $unsigned(w_q)};
                    end
                end
                OP_NEG:  o_res[W-1:0] = 32'd0 - i_b;
                OP_NOT:  o_res[W-1:0] = ~i_b;
                default: o_res[W-1:0] = i_b;
            endcase
        end
    end

endmodule

// File: rtl/datapath.sv
// Single-bus 32-bit CPU datapath with 512-word RAM.
// RAM starts all-zero; contents survive reset.
module datapath
    import datapath_pkg::*;
#(
    parameter int MEM_DEPTH = 512,
    parameter     MEM_FILE  = "memory.hex"
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic         HIin, LOin, PCin, MDRin, INPORTin,
    input  logic         Zin, Yin, MARin, IRin, CONin,
    input  logic         HIout, LOout, ZHIout, ZLOout, PCout,
    input  logic         MDRout, INPORTout, Cout, Yout,
    input  logic         OUTPORTout,
    input  logic         Gra, Grb, Grc, Rin, Rout, BAout,
    input  logic         Read, IncPC, write,
    input  logic [31:0]  inportInput,
    output logic [31:0]  busMuxOut,
    output logic [4:0]   encoderOut,
    output logic         CON,
    output logic [31:0]  BusMuxInR0, BusMuxInR1, BusMuxInR2, BusMuxInR3,
    output logic [31:0]  BusMuxInR4, BusMuxInR5, BusMuxInR6, BusMuxInR7,
    output logic [31:0]  BusMuxInR8, BusMuxInR9, BusMuxInR10, BusMuxInR11,
    output logic [31:0]  BusMuxInR12, BusMuxInR13, BusMuxInR14, BusMuxInR15,
    output logic [31:0]  BusMuxInHI, BusMuxInLO, BusMuxInZhi, BusMuxInZlo,
    output logic [31:0]  BusMuxInPC, BusMuxInMDR, BusMuxInInport,
    output logic [31:0]  BusMuxInOutport, BusMuxInY,
    output logic [31:0]  IRregister,
    output logic [31:0]  Cregister,
    output logic [8:0]   marToRam
);

    logic [W-1:0]    r_gpr [NREG];
    logic [W-1:0]    r_hi, r_lo, r_zhi, r_zlo, r_pc, r_mdr;
    logic [W-1:0]    r_in, r_out, r_y, r_ir;
    logic [AW-1:0]   r_mar;
    logic            r_con;
    logic [W-1:0]    r_mem [MEM_DEPTH];

    logic [NREG-1:0] w_sel, w_gpr_in, w_gpr_out;
    logic [4:0]      w_enc;
    logic [W-1:0]    w_bus, w_c;
    logic [2*W-1:0]  w_alu;
    logic            w_con_d;

    assign w_c = {{13{r_ir[18]}}, r_ir[18:0]};

    always_comb begin
        w_sel = '0;
        if (Gra) w_sel[r_ir[26:23]] = 1'b1;
        if (Grb) w_sel[r_ir[22:19]] = 1'b1;
        if (Grc) w_sel[r_ir[18:15]] = 1'b1;
    end

    assign w_gpr_in  = w_sel & {NREG{Rin}};
    assign w_gpr_out = w_sel & {NREG{Rout | BAout}};

    always_comb begin
        w_enc = SRC_ZLO;
        for (int i = 0; i < NREG; i++)
            if (w_gpr_out[i]) w_enc = 5'(i);
        if (HIout)     w_enc = SRC_HI;
        if (LOout)     w_enc = SRC_LO;
        if (ZHIout)    w_enc = SRC_ZHI;
        if (ZLOout)    w_enc = SRC_ZLO;
        if (PCout)     w_enc = SRC_PC;
        if (MDRout)    w_enc = SRC_MDR;
        if (INPORTout) w_enc = SRC_IN;
        if (Cout)      w_enc = SRC_C;
        if (Yout)      w_enc = SRC_Y;
    end

    always_comb begin
        w_bus = r_zlo;
        if (w_enc < 5'd16) begin
            if (w_enc == 5'd0 && BAout) w_bus = '0;
            else                        w_bus = r_gpr[w_enc[3:0]];
        end else begin
            case (w_enc)
                SRC_HI:  w_bus = r_hi;
                SRC_LO:  w_bus = r_lo;
                SRC_ZHI: w_bus = r_zhi;
                SRC_PC:  w_bus = r_pc;
                SRC_MDR: w_bus = r_mdr;
                SRC_IN:  w_bus = r_in;
                SRC_C:   w_bus = w_c;
                SRC_Y:   w_bus = r_y;
                default: w_bus = r_zlo;
            endcase
        end
    end

    always_comb begin
        case (r_ir[20:19])
            2'b00:   w_con_d = (w_bus == '0);
            2'b01:   w_con_d = (w_bus != '0);
            2'b10:   w_con_d = !w_bus[31] && (w_bus != '0);
            default: w_con_d = w_bus[31];
        endcase
    end

    alu u_alu (
        .i_a     (r_y),
        .i_b     (w_bus),
        .i_op    (r_ir[31:27]),
        .i_incpc (IncPC),
        .o_res   (w_alu)
    );

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < NREG; i++) r_gpr[i] <= '0;
        end else begin
            for (int i = 0; i < NREG; i++)
                if (w_gpr_in[i]) r_gpr[i] <= w_bus;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_hi  <= '0;
            r_lo  <= '0;
            r_zhi <= '0;
            r_zlo <= '0;
            r_pc  <= '0;
            r_mdr <= '0;
            r_in  <= '0;
            r_out <= '0;
            r_y   <= '0;
            r_ir  <= '0;
            r_mar <= '0;
            r_con <= 1'b0;
        end else begin
            if (HIin)       r_hi  <= w_bus;
            if (LOin)       r_lo  <= w_bus;
            if (Zin)        {r_zhi, r_zlo} <= w_alu;
            if (PCin)       r_pc  <= w_bus;
            if (MDRin)      r_mdr <= Read ? r_mem[r_mar] : w_bus;
            if (INPORTin)   r_in  <= inportInput;
            if (OUTPORTout) r_out <= w_bus;
            if (Yin)        r_y   <= w_bus;
            if (IRin)       r_ir  <= w_bus;
            if (MARin)      r_mar <= w_bus[AW-1:0];
            if (CONin)      r_con <= w_con_d;
        end
    end

    initial begin
        for (int i = 0; i < MEM_DEPTH; i++) r_mem[i] = '0;
    end

    always_ff @(posedge Clock) begin
        if (write) r_mem[r_mar] <= r_mdr;
    end

    assign busMuxOut       = w_bus;
    assign encoderOut      = w_enc;
    assign CON             = r_con;
    assign BusMuxInR0      = r_gpr[0];
    assign BusMuxInR1      = r_gpr[1];
    assign BusMuxInR2      = r_gpr[2];
    assign BusMuxInR3      = r_gpr[3];
    assign BusMuxInR4      = r_gpr[4];
    assign BusMuxInR5      = r_gpr[5];
    assign BusMuxInR6      = r_gpr[6];
    assign BusMuxInR7      = r_gpr[7];
    assign BusMuxInR8      = r_gpr[8];
    assign BusMuxInR9      = r_gpr[9];
    assign BusMuxInR10     = r_gpr[10];
    assign BusMuxInR11     = r_gpr[11];
    assign BusMuxInR12     = r_gpr[12];
    assign BusMuxInR13     = r_gpr[13];
    assign BusMuxInR14     = r_gpr[14];
    assign BusMuxInR15     = r_gpr[15];
    assign BusMuxInHI      = r_hi;
    assign BusMuxInLO      = r_lo;
    assign BusMuxInZhi     = r_zhi;
    assign BusMuxInZlo     = r_zlo;
    assign BusMuxInPC      = r_pc;
    assign BusMuxInMDR     = r_mdr;
    assign BusMuxInInport  = r_in;
    assign BusMuxInOutport = r_out;
    assign BusMuxInY       = r_y;
    assign IRregister      = r_ir;
    assign Cregister       = w_c;
    assign marToRam        = r_mar;

endmodule

// File: tb/tb_datapath.sv
// Bench for datapath: directed scenarios plus randomized
// register-transfer sequences against a behavioural model.
module tb_datapath;

    logic        clk = 1'b0;
    logic        Reset;
    logic        HIin, LOin, PCin, MDRin, INPORTin;
    logic        Zin, Yin, MARin, IRin, CONin;
    logic        HIout, LOout, ZHIout, ZLOout, PCout;
    logic        MDRout, INPORTout, Cout, Yout, OUTPORTout;
    logic        Gra, Grb, Grc, Rin, Rout, BAout;
    logic        Read, IncPC, write;
    logic [31:0] inportInput;
    logic [31:0] busMuxOut;
    logic [4:0]  encoderOut;
    logic        CON;
    logic [31:0] R0, R1, R2, R3, R4, R5, R6, R7;
    logic [31:0] R8, R9, R10, R11, R12, R13, R14, R15;
    logic [31:0] HI, LO, Zhi, Zlo, PC, MDR, Inport, Outport, Y;
    logic [31:0] IRregister, Cregister;
    logic [8:0]  marToRam;
    logic [31:0] o_r [16];

    always #5 clk = ~clk;

    datapath dut (
        .Clock(clk), .Reset(Reset),
        .HIin(HIin), .LOin(LOin), .PCin(PCin), .MDRin(MDRin),
        .INPORTin(INPORTin), .Zin(Zin), .Yin(Yin), .MARin(MARin),
        .IRin(IRin), .CONin(CONin),
        .HIout(HIout), .LOout(LOout), .ZHIout(ZHIout), .ZLOout(ZLOout),
        .PCout(PCout), .MDRout(MDRout), .INPORTout(INPORTout),
        .Cout(Cout), .Yout(Yout), .OUTPORTout(OUTPORTout),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
        .BAout(BAout), .Read(Read), .IncPC(IncPC), .write(write),
        .inportInput(inportInput),
        .busMuxOut(busMuxOut), .encoderOut(encoderOut), .CON(CON),
        .BusMuxInR0(R0), .BusMuxInR1(R1), .BusMuxInR2(R2),
        .BusMuxInR3(R3), .BusMuxInR4(R4), .BusMuxInR5(R5),
        .BusMuxInR6(R6), .BusMuxInR7(R7), .BusMuxInR8(R8),
        .BusMuxInR9(R9), .BusMuxInR10(R10), .BusMuxInR11(R11),
        .BusMuxInR12(R12), .BusMuxInR13(R13), .BusMuxInR14(R14),
        .BusMuxInR15(R15),
        .BusMuxInHI(HI), .BusMuxInLO(LO), .BusMuxInZhi(Zhi),
        .BusMuxInZlo(Zlo), .BusMuxInPC(PC), .BusMuxInMDR(MDR),
        .BusMuxInInport(Inport), .BusMuxInOutport(Outport),
        .BusMuxInY(Y), .IRregister(IRregister),
        .Cregister(Cregister), .marToRam(marToRam)
    );

    assign o_r[0]  = R0;
    assign o_r[1]  = R1;
    assign o_r[2]  = R2;
    assign o_r[3]  = R3;
    assign o_r[4]  = R4;
    assign o_r[5]  = R5;
    assign o_r[6]  = R6;
    assign o_r[7]  = R7;
    assign o_r[8]  = R8;
    assign o_r[9]  = R9;
    assign o_r[10] = R10;
    assign o_r[11] = R11;
    assign o_r[12] = R12;
    assign o_r[13] = R13;
    assign o_r[14] = R14;
    assign o_r[15] = R15;

    // behavioural model state
    logic [31:0] m_gpr [16];
    logic [31:0] m_hi, m_lo, m_zhi, m_zlo, m_pc, m_mdr;
    logic [31:0] m_in, m_out, m_y, m_ir;
    logic [8:0]  m_mar;
    logic        m_con;
    logic [31:0] m_mem [512];

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] c_of(input logic [31:0] ir);
        int v;
        v = int'($signed(ir[18:0]));
        return v;
    endfunction

    function automatic logic con_of(input logic [1:0] s,
                                    input logic [31:0] v);
        case (s)
            2'd0:    return v == 0;
            2'd1:    return v != 0;
            2'd2:    return int'(v) > 0;
            default: return int'(v) < 0;
        endcase
    endfunction

    function automatic logic [63:0] ref_alu(input logic [4:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        logic [31:0] x;
        int s;
        longint p;
        s = int'(b[4:0]);
        x = a;
        case (op)
            5'd0, 5'd1, 5'd2, 5'd3, 5'd12, 5'd19:
                return {32'd0, a + b};
            5'd4:  return {32'd0, a - b};
            5'd5, 5'd13: return {32'd0, a & b};
            5'd6, 5'd14: return {32'd0, a | b};
            5'd7: begin
                for (int i = 0; i < s; i++) x = {x[0], x[31:1]};
                return {32'd0, x};
            end
            5'd8: begin
                for (int i = 0; i < s; i++) x = {x[30:0], x[31]};
                return {32'd0, x};
            end
            5'd9:  return {32'd0, a >> s};
            5'd10: begin
                for (int i = 0; i < s; i++) x = {x[31], x[31:1]};
                return {32'd0, x};
            end
            5'd11: return {32'd0, a << s};
            5'd15: begin
                if (b == 0) return 64'd0;
                return {32'(int'(a) % int'(b)), 32'(int'(a) / int'(b))};
            end
            5'd16: begin
                p = longint'(int'(a)) * longint'(int'(b));
                return p;
            end
            5'd17: return {32'd0, 32'(32'd0 - b)};
            5'd18: return {32'd0, ~b};
            default: return {32'd0, b};
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_gpr[i] = '0;
        {m_hi, m_lo, m_zhi, m_zlo, m_pc, m_mdr} = '0;
        {m_in, m_out, m_y, m_ir} = '0;
        m_mar = '0;
        m_con = 1'b0;
    endtask

    task automatic clr();
        {HIin, LOin, PCin, MDRin, INPORTin} = '0;
        {Zin, Yin, MARin, IRin, CONin} = '0;
        {HIout, LOout, ZHIout, ZLOout, PCout} = '0;
        {MDRout, INPORTout, Cout, Yout, OUTPORTout} = '0;
        {Gra, Grb, Grc, Rin, Rout, BAout} = '0;
        {Read, IncPC, write} = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        clr();
    endtask

    // latch v into INPORT and leave it driving the bus
    task automatic put(input logic [31:0] v);
        inportInput = v;
        INPORTin = 1'b1;
        step();
        m_in = v;
        INPORTout = 1'b1;
    endtask

    task automatic load_ir(input logic [31:0] v);
        put(v); IRin = 1'b1; step(); m_ir = v;
    endtask

    task automatic load_y(input logic [31:0] v);
        put(v); Yin = 1'b1; step(); m_y = v;
    endtask

    task automatic load_pc(input logic [31:0] v);
        put(v); PCin = 1'b1; step(); m_pc = v;
    endtask

    task automatic load_gpr(input logic [3:0] k, input logic [31:0] v);
        load_ir({5'd0, k, 23'd0});
        put(v); Gra = 1'b1; Rin = 1'b1; step();
        m_gpr[k] = v;
    endtask

    task automatic load_mar(input logic [8:0] a);
        put({23'd0, a}); MARin = 1'b1; step(); m_mar = a;
    endtask

    task automatic mem_wr(input logic [8:0] a, input logic [31:0] v);
        put(v); MDRin = 1'b1; step(); m_mdr = v;
        load_mar(a);
        write = 1'b1; step();
        m_mem[a] = v;
    endtask

    task automatic mem_rd(input logic [8:0] a);
        load_mar(a);
        Read = 1'b1; MDRin = 1'b1; step();
        m_mdr = m_mem[a];
        check("mem_rd", MDR, m_mdr);
    endtask

    task automatic fetch();
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; step();
        m_mar = m_pc[8:0]; m_zlo = m_pc + 1; m_zhi = 0;
        Read = 1'b1; MDRin = 1'b1; ZLOout = 1'b1; PCin = 1'b1; step();
        m_mdr = m_mem[m_mar]; m_pc = m_zlo;
        MDRout = 1'b1; IRin = 1'b1; step();
        m_ir = m_mdr;
    endtask

    task automatic alu_run(input logic [31:0] ir, input logic [31:0] a,
                           input logic [31:0] b);
        load_ir(ir);
        load_y(a);
        put(b); Zin = 1'b1; step();
        {m_zhi, m_zlo} = ref_alu(ir[31:27], a, b);
        check($sformatf("alu%0d.zlo", ir[31:27]), Zlo, m_zlo);
        check($sformatf("alu%0d.zhi", ir[31:27]), Zhi, m_zhi);
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 16; i++)
            check($sformatf("%s.r%0d", tag, i), o_r[i], m_gpr[i]);
        check({tag, ".hi"}, HI, m_hi);
        check({tag, ".lo"}, LO, m_lo);
        check({tag, ".zhi"}, Zhi, m_zhi);
        check({tag, ".zlo"}, Zlo, m_zlo);
        check({tag, ".pc"}, PC, m_pc);
        check({tag, ".mdr"}, MDR, m_mdr);
        check({tag, ".in"}, Inport, m_in);
        check({tag, ".out"}, Outport, m_out);
        check({tag, ".y"}, Y, m_y);
        check({tag, ".ir"}, IRregister, m_ir);
        check({tag, ".c"}, Cregister, c_of(m_ir));
        check({tag, ".mar"}, marToRam, m_mar);
        check({tag, ".con"}, CON, m_con);
    endtask

    task automatic set_src(input int k, input logic v);
        case (k)
            0: HIout = v;
            1: LOout = v;
            2: ZHIout = v;
            3: ZLOout = v;
            4: PCout = v;
            5: MDRout = v;
            6: INPORTout = v;
            7: Cout = v;
            default: Yout = v;
        endcase
    endtask

    task automatic check_srcs();
        logic [31:0] exp [9];
        exp = '{m_hi, m_lo, m_zhi, m_zlo, m_pc, m_mdr, m_in,
                c_of(m_ir), m_y};
        clr();
        for (int k = 0; k < 9; k++) begin
            set_src(k, 1'b1);
            #1;
            check($sformatf("src%0d.bus", k), busMuxOut, exp[k]);
            check($sformatf("src%0d.enc", k), encoderOut, 16 + k);
            set_src(k, 1'b0);
        end
        #1;
        check("none.enc", encoderOut, 19);
        check("none.bus", busMuxOut, m_zlo);
        HIout = 1'b1; Yout = 1'b1;
        #1;
        check("multi.enc", encoderOut, 24);
        check("multi.bus", busMuxOut, m_y);
        clr();
    endtask

    initial begin
        logic [4:0]  op;
        logic [31:0] a, b, t, ir;
        logic [3:0]  ra, rb, rc;

        clr();
        inportInput = '0;
        for (int i = 0; i < 512; i++) m_mem[i] = '0;
        model_reset();
        Reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_all("rst");
        Reset = 1'b0;

        put(32'd8);
        PCin = 1'b1;
        #1;
        check("inpc.enc", encoderOut, 22);
        check("inpc.bus", busMuxOut, 32'd8);
        step();
        m_pc = 32'd8;
        check("inpc.pc", PC, 32'd8);

        load_gpr(4'd3, 32'd5);
        mem_wr(9'd12, 32'hDEAD);
        check("pre.r3", R3, 32'd5);
        check("pre.pc", PC, 32'd8);
        #2 Reset = 1'b1;
        #1;
        model_reset();
        check_all("arst");
        Reset = 1'b0;
        mem_rd(9'd12);
        check("keep.mdr", MDR, 32'hDEAD);

        mem_wr(9'd8, 32'h71180053);
        load_gpr(4'd3, 32'h24);
        load_pc(32'd8);
        fetch();
        check("fetch.pc", PC, 32'd9);
        check("fetch.ir", IRregister, 32'h71180053);
        Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; step();
        m_y = m_gpr[3];
        Cout = 1'b1; Zin = 1'b1; step();
        {m_zhi, m_zlo} = ref_alu(m_ir[31:27], m_y, c_of(m_ir));
        ZLOout = 1'b1; Gra = 1'b1; Rin = 1'b1; step();
        m_gpr[2] = m_zlo;
        check("ori.r2", R2, 32'h77);
        check_all("ori");

        alu_run({5'd16, 27'd0}, -32'sd3, 32'd7);
        check("mul.hi", Zhi, 32'hFFFFFFFF);
        check("mul.lo", Zlo, 32'hFFFFFFEB);
        alu_run({5'd15, 27'd0}, 32'd17, 32'd5);
        check("div.lo", Zlo, 32'd3);
        check("div.hi", Zhi, 32'd2);
        alu_run({5'd15, 27'd0}, 32'd17, 32'd0);
        check("div0.lo", Zlo, 32'd0);

        load_ir(32'h00180000);
        put(32'h80000000); CONin = 1'b1; step();
        check("con.neg", CON, 1'b1);
        put(32'd0); CONin = 1'b1; step();
        check("con.zero", CON, 1'b0);
        m_con = 1'b0;

        load_gpr(4'd0, 32'd7);
        load_ir(32'd0);
        BAout = 1'b1; Grb = 1'b1;
        #1;
        check("ba.r0", busMuxOut, 32'd0);
        clr();
        Rout = 1'b1; Grb = 1'b1;
        #1;
        check("rout.r0", busMuxOut, 32'd7);
        clr();
        check_srcs();

        for (int it = 0; it < 40; it++) begin
            op = 5'($urandom_range(0, 23));
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 3) == 0) b = $urandom_range(0, 40);
            if (op == 5'd15 && $urandom_range(0, 5) == 0) b = 0;
            if (op == 5'd15 && a == 32'h80000000 && b == 32'hFFFFFFFF)
                a = 32'd1;
            t = $urandom;
            ir = {op, t[26:0]};
            ra = ir[26:23];
            rb = ir[22:19];
            rc = ir[18:15];
            alu_run(ir, a, b);
            ZLOout = 1'b1; Gra = 1'b1; Rin = 1'b1; step();
            m_gpr[ra] = m_zlo;
            ZHIout = 1'b1; HIin = 1'b1; step();
            m_hi = m_zhi;
            ZLOout = 1'b1; LOin = 1'b1; step();
            m_lo = m_zlo;
            Rout = 1'b1; Grb = 1'b1; CONin = 1'b1; OUTPORTout = 1'b1;
            step();
            m_con = con_of(m_ir[20:19], m_gpr[rb]);
            m_out = m_gpr[rb];
            check("rnd.con", CON, m_con);
            BAout = 1'b1; Grc = 1'b1;
            #1;
            check("rnd.ba", busMuxOut, (rc == 0) ? 32'd0 : m_gpr[rc]);
            check("rnd.baenc", encoderOut, {1'b0, rc});
            clr();
            mem_wr(9'($urandom_range(0, 511)), $urandom);
            mem_rd(9'($urandom_range(0, 511)));
            if (it % 8 == 7) begin
                load_pc($urandom_range(0, 511));
                fetch();
                check_all($sformatf("it%0d", it));
                check_srcs();
            end
        end

        check_all("end");
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
